jpeg_rle_expander: RTL

Decoder-side run-length expander for the JPEG timing-cone suite. It sits between the entropy/Huffman decoder and the dequantiser/inverse-zigzag stage. It takes (run, value) symbols, including EOB and ZRL, and expands them into exactly 64 coefficients per 8x8 block in zigzag order. Both sides use valid/ready handshakes.

---
 rtl/jpeg_pkg.sv | 21 ++
 rtl/jpeg_coef_outreg.sv | 65 ++++++
 rtl/jpeg_rle_expander.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG run-length expander and its neighbours.
package jpeg_pkg;

    localparam int         COEF_W  = 12;
    localparam int         BLK_LEN = 64;
    localparam logic [3:0] RUN_ZRL = 4'd15;

    typedef enum logic [1:0] {
        ACCEPT,
        ZEROS,
        VALUE,
        FILL
    } state_t;

    typedef struct packed {
        logic [3:0]        run;
        logic [COEF_W-1:0] coef;
        logic              eob;
    } sym_t;

endpackage

// File: rtl/jpeg_coef_outreg.sv
// Single-entry output register for a coefficient stream.
// It holds data, idx and last stable while the consumer stalls.
// It accepts a new entry whenever it is empty or is being drained in the same cycle.
module jpeg_coef_outreg
    import jpeg_pkg::*;
#(
    parameter int COEF_W = jpeg_pkg::COEF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [COEF_W-1:0] in_data,
    input  logic [5:0]        in_idx,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [COEF_W-1:0] out_data,
    output logic [5:0]        out_idx,
    output logic              out_last
);

    logic              valid_q, valid_d;
    logic [COEF_W-1:0] data_q, data_d;
    logic [5:0]        idx_q, idx_d;
    logic              last_q, last_d;

    // Load a new entry when there is room; otherwise hold everything unchanged.
    always_comb begin
        in_ready = !valid_q || out_ready;
        valid_d  = valid_q;
        data_d   = data_q;
        idx_d    = idx_q;
        last_d   = last_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
                idx_d  = in_idx;
                last_d = in_last;
            end
        end
    end

    // Register the entry; reset empties it and clears the presented fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;

endmodule

// File: rtl/jpeg_rle_expander.sv
// Run-length expander: turns (run, value), ZRL and EOB symbols into 64 zigzag coefficients per block.
// Each generated coefficient goes straight into the output register.
// A coefficient produced in the accept cycle is therefore presented on the following cycle.
module jpeg_rle_expander
    import jpeg_pkg::*;
#(
    parameter int COEF_W  = jpeg_pkg::COEF_W,
    parameter int BLK_LEN = jpeg_pkg::BLK_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sym_valid,
    output logic              sym_ready,
    input  logic [3:0]        sym_run,
    input  logic [COEF_W-1:0] sym_coef,
    input  logic              sym_eob,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic [COEF_W-1:0] coef_data,
    output logic [5:0]        coef_idx,
    output logic              coef_last,
    output logic              blk_err
);

    if (BLK_LEN != 64) begin : g_blk_len_check
        $error("jpeg_rle_expander: BLK_LEN must be 64");
    end

    state_t            state_q, state_d;
    logic [5:0]        idx_q, idx_d;
    logic [3:0]        run_q, run_d;
    logic [COEF_W-1:0] coef_q, coef_d;
    logic              err_q, err_d;

    logic              gen_valid;
    logic [COEF_W-1:0] gen_data;
    logic              oreg_ready;
    logic              at_last;

    // Next state and coefficient generation.
    // Every coefficient is generated only when the output register can take it,
    // so a stall freezes state, run and index together.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        run_d     = run_q;
        coef_d    = coef_q;
        err_d     = err_q;
        gen_valid = 1'b0;
        gen_data  = '0;
        at_last   = (idx_q == 6'd63);
        sym_ready = !rst && (state_q == ACCEPT) && oreg_ready;

        case (state_q)
            ACCEPT: begin
                if (sym_valid && sym_ready) begin
                    gen_valid = 1'b1;
                    if (idx_q == 6'd0) begin
                        err_d = !sym_eob && (sym_run != 4'd0);
                    end
                    if (sym_eob) begin
                        if (!at_last) begin
                            state_d = FILL;
                        end
                    end else if ((sym_run == 4'd0) || (idx_q == 6'd0)) begin
                        gen_data = sym_coef;
                    end else if (at_last) begin
                        err_d = 1'b1;
                    end else begin
                        run_d   = sym_run - 4'd1;
                        coef_d  = sym_coef;
                        state_d = (sym_run == 4'd1) ? VALUE : ZEROS;
                    end
                end
            end
            ZEROS: begin
                if (oreg_ready) begin
                    gen_valid = 1'b1;
                    if (at_last) begin
                        err_d   = 1'b1;
                        state_d = ACCEPT;
                    end else begin
                        run_d = run_q - 4'd1;
                        if (run_q == 4'd1) begin
                            state_d = VALUE;
                        end
                    end
                end
            end
            VALUE: begin
                if (oreg_ready) begin
                    gen_valid = 1'b1;
                    gen_data  = coef_q;
                    state_d   = ACCEPT;
                end
            end
            FILL: begin
                if (oreg_ready) begin
                    gen_valid = 1'b1;
                    if (at_last) begin
                        state_d = ACCEPT;
                    end
                end
            end
            default: state_d = ACCEPT;
        endcase

        if (gen_valid) begin
            idx_d = idx_q + 6'd1;
        end
    end

    // State, index, latched symbol and sticky block error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCEPT;
            idx_q   <= '0;
            run_q   <= '0;
            coef_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
            coef_q  <= coef_d;
            err_q   <= err_d;
        end
    end

    assign blk_err = err_q;

    jpeg_coef_outreg #(.COEF_W(COEF_W)) u_outreg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (gen_valid),
        .in_data   (gen_data),
        .in_idx    (idx_q),
        .in_last   (at_last),
        .in_ready  (oreg_ready),
        .out_valid (coef_valid),
        .out_ready (coef_ready),
        .out_data  (coef_data),
        .out_idx   (coef_idx),
        .out_last  (coef_last)
    );

endmodule
